dmem_arbiter: RTL

//  Two-master arbiter that shares the single 256-bit data-memory port between the I-cache (m0) and D-cache (m1) miss engines.
//  It grants the port one transaction at a time, round-robin, and latches the winner's command. It drives the memory handshake
//  and routes the ack and read data back to the winner. A watchdog flags a memory that never acks.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arb_watchdog.sv | 40 ++++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned N_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arb_watchdog.sv
// Busy-cycle watchdog: expire_o fires on the TIMEOUT-th counted cycle since the last clear.
module dmem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    if (TIMEOUT == 0) begin : g_off
        assign expire_o = 1'b0;
    end else begin : g_on
        localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

        logic [TO_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (inc_i) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expire_o = inc_i && (cnt_q == LAST);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between the I-cache (m0) and
// D-cache (m1) miss engines, with a sticky no-ack watchdog flag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              winner;
    logic              wd_clr, wd_expire;
    logic              busy;

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        en_d    = en_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        wd_clr  = 1'b0;
        winner  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_enable_i || m1_enable_i) begin
                    // On contention the master that did not win last time gets the port.
                    winner  = (m0_enable_i && m1_enable_i) ? ~last_q : m1_enable_i;
                    gnt_d   = winner;
                    last_d  = winner;
                    en_d    = 1'b1;
                    wr_d    = winner ? m1_write_i : m0_write_i;
                    addr_d  = winner ? m1_addr_i  : m0_addr_i;
                    data_d  = winner ? m1_data_i  : m0_data_i;
                    wd_clr  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    en_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_TURN;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    dmem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .inc_i    (busy),
        .expire_o (wd_expire)
    );

    assign m0_ack_o     = busy && mem_ack_i && !gnt_q;
    assign m1_ack_o     = busy && mem_ack_i && gnt_q;
    assign m0_data_o    = mem_data_i;
    assign m1_data_o    = mem_data_i;
    assign mem_enable_o = en_q;
    assign mem_write_o  = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign err_o        = err_q;

endmodule
